// File: rtl/uart_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_program_loader                                          |
// | Description : Receives a program image over an 8N1 UART and writes it into |
// |               program memory one 32-bit word at a time. The image is a     |
// |               16-bit little-endian word count N followed by N words, each  |
// |               sent least-significant byte first. The CPU core is held in   |
// |               reset until the image is complete.                           |
// | Ports       : clk              - clock, all logic on posedge               |
// |               reset_n          - synchronous active-low reset              |
// |               io_rx            - asynchronous UART RX line, idle high      |
// |               mem_write_enable - one-cycle program memory write strobe     |
// |               mem_address      - word-aligned byte address of the write    |
// |               mem_write_data   - word to write                             |
// |               loading          - header or words still outstanding         |
// |               load_done        - image fully received (sticky)             |
// |               cpu_reset_n      - active-low core reset, released when done |
// |               frame_error      - sticky, a byte had a stop bit of 0        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_program_loader #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        loading,
  output logic        load_done,
  output logic        cpu_reset_n,
  output logic        frame_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  // Terminal counts of the per-bit clock counter (guarded against tiny ratios).
  localparam logic [31:0] c_BIT_LAST  = (CLKS_PER_BIT > 0) ? 32'(CLKS_PER_BIT - 1) : 32'd0;
  localparam logic [31:0] c_HALF_LAST = (HALF_BIT > 0)     ? 32'(HALF_BIT - 1)     : 32'd0;
  localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t   rx_state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [31:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        byte_valid_q;
  logic        frame_error_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      clk_cnt_q     <= 32'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q    <= io_rx;
      rx_sync_q    <= rx_meta_q;
      byte_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          clk_cnt_q <= 32'd0;
          bit_cnt_q <= 3'd0;
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the line mid start bit to reject glitches.
          if (clk_cnt_q == c_HALF_LAST) begin
            clk_cnt_q  <= 32'd0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == c_BIT_LAST) begin
            clk_cnt_q <= 32'd0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == c_BIT_LAST) begin
            clk_cnt_q  <= 32'd0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // shift_q only changes in RX_DATA, so it is stable while byte_valid_q is high.
  logic [7:0] rx_byte;
  assign rx_byte = shift_q;

  // --------------------------------------------------------------------------
  // Image loader
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    LD_LEN_LO = 2'd0,
    LD_LEN_HI = 2'd1,
    LD_WORD   = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_t;

  ld_state_t   ld_state_q;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        loading_q;
  logic        load_done_q;
  logic        cpu_rst_n_q;

  // Full word once the current byte lands in the top lane.
  logic [31:0] asm_word_d;
  assign asm_word_d = {rx_byte, word_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_state_q  <= LD_LEN_LO;
      len_q       <= 16'd0;
      word_idx_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_data_q  <= 32'd0;
      loading_q   <= 1'b1;
      load_done_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      // Released one cycle after the FSM reaches DONE; DONE is only left by reset.
      load_done_q <= (ld_state_q == LD_DONE);
      cpu_rst_n_q <= (ld_state_q == LD_DONE);
      if (byte_valid_q) begin
        case (ld_state_q)
          LD_LEN_LO: begin
            len_q[7:0] <= rx_byte;
            ld_state_q <= LD_LEN_HI;
          end
          LD_LEN_HI: begin
            len_q[15:8] <= rx_byte;
            if ({rx_byte, len_q[7:0]} != 16'd0) begin
              ld_state_q <= LD_WORD;
            end else begin
              ld_state_q <= LD_DONE;
              loading_q  <= 1'b0;
            end
          end
          LD_WORD: begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    word_q[7:0]   <= rx_byte;
              2'd1:    word_q[15:8]  <= rx_byte;
              2'd2:    word_q[23:16] <= rx_byte;
              default: word_q        <= word_q;
            endcase
            if (byte_idx_q == 2'd3) begin
              // Words beyond the memory are consumed but never written.
              mem_we_q   <= ({16'd0, word_idx_q} < c_MEM_WORDS);
              mem_addr_q <= {14'd0, word_idx_q, 2'b00};
              mem_data_q <= asm_word_d;
              word_idx_q <= word_idx_q + 16'd1;
              if (word_idx_q == len_q - 16'd1) begin
                ld_state_q <= LD_DONE;
                loading_q  <= 1'b0;
              end
            end
          end
          default: ld_state_q <= LD_DONE;
        endcase
      end
    end
  end

  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_data_q;
  assign loading          = loading_q;
  assign load_done        = load_done_q;
  assign cpu_reset_n      = cpu_rst_n_q;
  assign frame_error      = frame_error_q;

endmodule
`default_nettype wire

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter: CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide).
REQ-003 Parameter: MEM_WORDS, default 1024, program memory depth in 32-bit words.
REQ-004 Port: clk  input  1  clock; all logic on posedge.
REQ-005 Port: reset_n  input  1  synchronous, active-low reset.
REQ-006 Port: io_rx  input  1  asynchronous UART RX line, 8N1, LSB first, idle high.
REQ-007 Port: mem_write_enable  output  1  one-cycle write strobe to program memory.
REQ-008 Port: mem_address  output  32  byte address of the current write; always word-aligned.
REQ-009 Port: mem_write_data  output  32  word to write.
REQ-010 Port: loading  output  1  high while the header or words are still outstanding.
REQ-011 Port: load_done  output  1  high once the image is fully received; sticky until reset.
REQ-012 Port: cpu_reset_n  output  1  active-low core reset; low until load_done.
REQ-013 Port: frame_error  output  1  sticky flag; set when any byte has a stop bit of 0.

Function
REQ-014 io_rx shall pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronized 0 moves the FSM to START and clears the bit counter.
REQ-016 START: sample at CLKS_PER_BIT/2 cycles.
- Line 0: go to DATA.
- Line 1: false start; return to IDLE and emit no byte.
REQ-017 DATA: sample every CLKS_PER_BIT cycles, taking 8 samples LSB first into a shift register; go to STOP after bit 7.
REQ-018 STOP: sample after CLKS_PER_BIT cycles.
- Line 1: pulse byte_valid internally for one cycle, then go to IDLE.
- Line 0: set frame_error, discard the byte, go to IDLE.
REQ-019 Loader FSM states: LEN_LO, LEN_HI, WORD, DONE; advances only on byte_valid.
REQ-020 LEN_LO stores byte as N[7:0].
- LEN_HI stores byte as N[15:8].
- Next state is WORD if N≠0, else DONE.
REQ-021 WORD assembles bytes little-endian: byte k → word[8k+7:8k], k=0..3.
- On the 4th byte, the following cycle drives mem_write_enable=1 with mem_address=4*word_index and mem_write_data=assembled word.
- word_index then increments.
REQ-022 After word N-1 is written, go to DONE in the same cycle as the write strobe.
REQ-023 A word with word_index ≥ MEM_WORDS shall be consumed but not written (no strobe); the word count still advances.
REQ-024 DONE ignores all further bytes; only reset_n restarts loading.
REQ-025 load_done=1 and cpu_reset_n=1 from the cycle after entering DONE.
- cpu_reset_n=0 in every other state.
REQ-026 loading = 1 in LEN_LO, LEN_HI and WORD; 0 in DONE.
REQ-027 mem_address and mem_write_data shall hold their last values when mem_write_enable=0.
- The RX FSM keeps running in every loader state.
REQ-028 A frame error does not alter the loader FSM; the next valid byte continues the sequence.

Reset
REQ-029 While reset_n=0 at a posedge, the following shall hold:
- RX FSM to IDLE; loader FSM to LEN_LO; counters, N and word_index to 0.
- mem_write_enable=0, mem_address=0, mem_write_data=0.
- loading=1, load_done=0, cpu_reset_n=0, frame_error=0.
REQ-030 Reset asserted mid-byte or mid-word shall drop the partial byte or word; no write strobe follows.

Verification
REQ-031 Bench settings: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clks/bit).
- Send 02 00 | 13 00 00 00 | B3 00 10 00 → exactly two strobes: (0x0, 0x00000013) and (0x4, 0x001000B3).
- Then load_done=1, cpu_reset_n=1.
REQ-032 Header 00 00 → zero strobes; load_done=1 one cycle after the 2nd stop bit.
REQ-033 A 2-clk low glitch on io_rx in IDLE → no byte emitted, FSM returns to IDLE, state unchanged.
REQ-034 Send a byte with stop bit 0 inside a word → frame_error=1.
- That byte is skipped; the next 4 valid bytes form the word.
REQ-035 Send N=3 and 1.5 words, then pulse reset_n low → no strobe, loading=1.
- Then send 01 00 AA BB CC DD → single strobe at 0x0 with 0xDDCCBBAA.
REQ-036 Set MEM_WORDS=1 and N=2 → exactly one strobe at 0x0; load_done=1 after the 8th word byte.
